// File: rtl/nibble_adder_pkg.sv
// nibble_adder_pkg: shared state encoding and sizing helpers for the nibble-serial adder
package nibble_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NIBBLE_W = 4;
    function automatic int cnt_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fulladder.sv
// fulladder: 4-bit ripple-carry adder slice
module fulladder (
    input  logic [3:0] i0,
    input  logic [3:0] i1,
    input  logic       cin,
    output logic [3:0] o,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign o[i]   = i0[i] ^ i1[i] ^ c[i];
        assign c[i+1] = (i0[i] & i1[i]) | (c[i] & (i0[i] ^ i1[i]));
    end
    assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide adder that reuses one 4-bit ripple slice, one nibble per clock, LSB first
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int CW = cnt_w(NIBBLES);
    state_t state, state_nx;
    logic [W-1:0] a_sh, b_sh, acc;
    logic [CW-1:0] cnt;
    logic [NIBBLE_W-1:0] o;
    logic carry_q, co, accept, last;
    fulladder u_fa (
        .i0  (a_sh[NIBBLE_W-1:0]),
        .i1  (b_sh[NIBBLE_W-1:0]),
        .cin (carry_q),
        .o   (o),
        .cout(co)
    );
    always_comb begin
        accept   = (state == IDLE || state == DONE) && start;
        last     = state == RUN && cnt == CW'(NIBBLES - 1);
        state_nx = accept ? RUN : last ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            acc     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            busy  <= state_nx == RUN;
            done  <= state_nx == DONE;
            if (accept) begin
                a_sh    <= a;
                b_sh    <= b;
                carry_q <= cin;
                cnt     <= '0;
            end else if (state == RUN) begin
                acc     <= {o, acc[W-1:NIBBLE_W]};
                a_sh    <= a_sh >> NIBBLE_W;
                b_sh    <= b_sh >> NIBBLE_W;
                carry_q <= co;
                cnt     <= cnt + 1'b1;
                if (last) begin
                    sum  <= {o, acc[W-1:NIBBLE_W]};
                    cout <= co;
                end
            end
        end
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle W-bit adder sequencer that sits directly in front of, and behind, the team's 4-bit ripple-carry adder `fulladder`. It captures two wide operands on a start handshake, feeds them to the 4-bit adder one nibble per clock (least-significant first), and chains the carry through a register. It then assembles the nibble sums into a full-width result with a one-cycle `done` pulse. This lets wide additions reuse the single 4-bit adder datapath instead of instantiating a wider ripple chain.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices; operand width W = 4*NIBBLES (16 by default); legal range 2..16.
- `clk`  input  1  single clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  input  1  request; sampled on rising edge, accepted only in IDLE or DONE.
- `a`  input  W  operand A; captured on the accepting edge.
- `b`  input  W  operand B; captured on the accepting edge.
- `cin`  input  1  carry-in to nibble 0; captured on the accepting edge.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse: `sum` and `cout` hold a new result.
- `sum`  output  W  registered result; holds until the next completion.
- `cout`  output  1  registered carry-out of the top nibble; holds with `sum`.

## Operation
- States:
  - IDLE: `busy` = 0, `done` = 0.
  - RUN: `busy` = 1.
  - DONE: `done` = 1 for exactly one cycle.
- Accept condition: (state == IDLE or DONE) and `start` == 1. On accept:
  - `a_sh` <= `a`, `b_sh` <= `b`, `carry_q` <= `cin`, `cnt` <= 0, state -> RUN.
- `start` in RUN is ignored. No queueing; operands are not re-sampled.
- Each RUN edge:
  - Adder inputs are `i0` = `a_sh[3:0]`, `i1` = `b_sh[3:0]`, cin = `carry_q`.
  - `acc` shifts right 4 with the adder's 4-bit `o` inserted at `acc[W-1:W-4]`.
  - `carry_q` <= adder carry-out.
  - `a_sh` and `b_sh` shift right 4, zero-filled.
  - `cnt` increments.
- At `cnt` == NIBBLES-1 (last RUN edge):
  - `sum` <= {`o`, `acc[W-1:4]`} (final assembled value).
  - `cout` <= adder carry-out.
  - State -> DONE.
- DONE with no `start` -> IDLE. DONE with `start` -> RUN (back-to-back accept); `done` still pulses that cycle.
- Arithmetic: {`cout`, `sum`} = `a` + `b` + `cin` exactly, modulo 2^(W+1). No overflow flag.
- `sum` and `cout` change only on the completion edge. Intermediate `acc` values never appear on outputs.
- Reset (async, `reset` == 0) clears everything immediately, including mid-RUN:
  - State -> IDLE.
  - `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0.
  - `acc`, `a_sh`, `b_sh`, `carry_q`, `cnt` = 0.
  - The in-flight operation is discarded. The first `start` after release is handled normally.

## Timing
- Accepting edge = E0. Nibble k is added on edge E(k+1).
- Result is registered on edge E(NIBBLES). `done` is high between E(NIBBLES) and E(NIBBLES+1).
- Start-to-`done` latency is NIBBLES edges (4 by default).
- `busy` is high from after E0 to E(NIBBLES).
- Back-to-back throughput: one result per NIBBLES+1 cycles (start held high, or re-asserted during DONE).
- The adder path is purely combinational between registers: one 4-bit ripple per cycle. The critical path is `carry_q` -> 4 full-adder stages -> `carry_q`/`acc`.
- Reset de-assertion should be synchronised externally. The block itself treats `reset` as fully asynchronous.

## Structure
- Shared package `nibble_adder_pkg`:
  - State enum {IDLE, RUN, DONE} (2-bit encoding).
  - Constant NIBBLE_W = 4.
  - Width function for `cnt`: clog2(NIBBLES), minimum 1.
- One sub-module: `fulladder` (existing 4-bit adder, ports `i0`, `i1`, `cin`, `o`, `cout`), instantiated once. No other hierarchy.
- FSM next-state logic and datapath registers live in this module. Outputs are registered; none are combinational.

## Test plan
1. `a`=0x0000, `b`=0x0000, `cin`=0 -> `sum`=0x0000, `cout`=0. `done` on the 4th edge after accept; `busy` high exactly 4 cycles.
2. `a`=0x1234, `b`=0x4321, `cin`=0 -> `sum`=0x5555, `cout`=0. Reset values (`sum`=0, `cout`=0, `done`=0) checked before the first start.
3. `a`=0xFFFF, `b`=0x0001, `cin`=0 -> `sum`=0x0000, `cout`=1 (carry chained through all nibbles). `a`=0x0FFF, `b`=0x0000, `cin`=1 -> `sum`=0x1000, `cout`=0.
4. Accept `a`=0x1111, `b`=0x1111, then pulse `start` with `a`=0xFFFF mid-RUN -> ignored. Result is 0x2222, `cout`=0.
5. `start` held high across DONE with `a`=0xA5A5, `b`=0x5A5A, `cin`=1 -> first result `done`. Next accept occurs in the DONE cycle. Second result `sum`=0x0000, `cout`=1, delivered 5 cycles after the first `done`.
6. `reset` driven low 2 cycles into RUN -> outputs immediately 0 and state IDLE. After release, `a`=0x0009, `b`=0x0007, `cin`=0 -> `sum`=0x0010, `cout`=0.
